// File: rtl/sram_controller_if.sv
// MEM-stage request bus and 16-bit asynchronous SRAM pins for sram_controller.
`default_nettype none

interface sram_controller_if #(
  parameter int SRAM_AW = 18
);
  logic               wr_en;
  logic               rd_en;
  logic [31:0]        address;
  logic [31:0]        write_data;
  logic [31:0]        read_data;
  logic               ready;
  logic [SRAM_AW-1:0] sram_addr;
  logic               sram_we_n;
  logic [15:0]        sram_dq_out;
  logic               sram_dq_oe;
  logic [15:0]        sram_dq_in;

  modport slave (
    input  wr_en, rd_en, address, write_data, sram_dq_in,
    output read_data, ready, sram_addr, sram_we_n, sram_dq_out, sram_dq_oe
  );

  modport master (
    output wr_en, rd_en, address, write_data, sram_dq_in,
    input  read_data, ready, sram_addr, sram_we_n, sram_dq_out, sram_dq_oe
  );
endinterface

`default_nettype wire

// File: rtl/sram_controller.sv
// Splits one 32-bit load/store into two sequenced half-word accesses on a 16-bit async SRAM;
// ready stays low for the whole access so the pipeline freezes.
`default_nettype none

module sram_controller #(
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int          SRAM_AW     = 18,
  parameter int          WAIT_CYCLES = 2
) (
  input  wire logic            clock,
  input  wire logic            reset,
  sram_controller_if.slave     bus
);

  localparam int                CNT_W    = $clog2(WAIT_CYCLES);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACC_LO = 2'd1,
    ACC_HI = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               op_wr_q, op_wr_d;
  logic [SRAM_AW-2:0] word_q, word_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [SRAM_AW-1:0] sram_addr_q, sram_addr_d;
  logic               sram_we_n_q, sram_we_n_d;
  logic               sram_dq_oe_q, sram_dq_oe_d;
  logic [15:0]        sram_dq_out_q, sram_dq_out_d;
  logic               ready_w;
  logic               req_w;
  logic               last_w;
  logic [SRAM_AW-2:0] word_w;

  assign req_w  = bus.rd_en | bus.wr_en;
  assign last_w = (cnt_q == LAST_CNT);
  // Out-of-range addresses simply wrap through the truncation.
  assign word_w = (SRAM_AW-1)'((bus.address - BASE_ADDR) >> 2);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      op_wr_q       <= 1'b0;
      word_q        <= '0;
      wdata_q       <= '0;
      rdata_q       <= '0;
      sram_addr_q   <= '0;
      sram_we_n_q   <= 1'b1;
      sram_dq_oe_q  <= 1'b0;
      sram_dq_out_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      op_wr_q       <= op_wr_d;
      word_q        <= word_d;
      wdata_q       <= wdata_d;
      rdata_q       <= rdata_d;
      sram_addr_q   <= sram_addr_d;
      sram_we_n_q   <= sram_we_n_d;
      sram_dq_oe_q  <= sram_dq_oe_d;
      sram_dq_out_q <= sram_dq_out_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    op_wr_d       = op_wr_q;
    word_d        = word_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;
    sram_addr_d   = sram_addr_q;
    sram_we_n_d   = 1'b1;
    sram_dq_oe_d  = 1'b0;
    sram_dq_out_d = '0;

    case (state_q)
      IDLE: begin
        if (req_w) begin
          op_wr_d = bus.wr_en;
          word_d  = word_w;
          wdata_d = bus.write_data;
          cnt_d   = '0;
          state_d = ACC_LO;
        end
      end
      ACC_LO: begin
        if (last_w) begin
          if (!op_wr_q) rdata_d[15:0] = bus.sram_dq_in;
          cnt_d   = '0;
          state_d = ACC_HI;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ACC_HI: begin
        if (last_w) begin
          if (!op_wr_q) rdata_d[31:16] = bus.sram_dq_in;
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // SRAM pins are registered from the next state; the strobe rises on the last wait cycle for hold time.
    case (state_d)
      ACC_LO: begin
        sram_addr_d   = {word_d, 1'b0};
        sram_dq_oe_d  = op_wr_d;
        sram_dq_out_d = op_wr_d ? wdata_d[15:0] : 16'h0000;
        sram_we_n_d   = ~(op_wr_d && (cnt_d < LAST_CNT));
      end
      ACC_HI: begin
        sram_addr_d   = {word_d, 1'b1};
        sram_dq_oe_d  = op_wr_d;
        sram_dq_out_d = op_wr_d ? wdata_d[31:16] : 16'h0000;
        sram_we_n_d   = ~(op_wr_d && (cnt_d < LAST_CNT));
      end
      default: ;
    endcase
  end

  always_comb begin
    ready_w = 1'b0;
    if (!reset) begin
      ready_w = 1'b1;
    end else begin
      case (state_q)
        IDLE:    ready_w = ~req_w;
        DONE:    ready_w = 1'b1;
        default: ready_w = 1'b0;
      endcase
    end
  end

  assign bus.ready       = ready_w;
  assign bus.read_data   = rdata_q;
  assign bus.sram_addr   = sram_addr_q;
  assign bus.sram_we_n   = sram_we_n_q;
  assign bus.sram_dq_oe  = sram_dq_oe_q;
  assign bus.sram_dq_out = sram_dq_out_q;

endmodule

`default_nettype wire

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller with a cycle-based behavioural 16-bit SRAM.
`default_nettype none

module tb_sram_controller;

  logic clock;
  logic reset;
  int   checks;
  int   passed;

  sram_controller_if #(.SRAM_AW(18)) bus ();

  sram_controller #(
    .BASE_ADDR   (32'd1024),
    .SRAM_AW     (18),
    .WAIT_CYCLES (2)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  logic [15:0] mem [0:63] = '{4: 16'h1111, 5: 16'h2222, default: 16'h0000};

  assign bus.sram_dq_in = mem[bus.sram_addr[5:0]];

  always @(negedge clock) begin
    if (!bus.sram_we_n && bus.sram_dq_oe) mem[bus.sram_addr[5:0]] <= bus.sram_dq_out;
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset          = 1'b0;
    bus.rd_en      = 1'b1;
    bus.wr_en      = 1'b0;
    bus.address    = 32'd1028;
    bus.write_data = 32'h0;
    #12;
    checks++; if (bus.ready !== 1'b1) $display("FAIL reset_ready got %0b want 1", bus.ready); else passed++;
    checks++; if (bus.sram_we_n !== 1'b1) $display("FAIL reset_we_n got %0b want 1", bus.sram_we_n); else passed++;
    checks++; if (bus.sram_dq_oe !== 1'b0) $display("FAIL reset_oe got %0b want 0", bus.sram_dq_oe); else passed++;
    checks++; if (bus.read_data !== 32'h0) $display("FAIL reset_rdata got %h want 0", bus.read_data); else passed++;
    next_cycle();
    reset = 1'b1;
    #1;
    checks++; if (bus.ready !== 1'b0) $display("FAIL release_ready got %0b want 0", bus.ready); else passed++;
    bus.rd_en = 1'b0;
    #1;
    checks++; if (bus.ready !== 1'b1) $display("FAIL idle_ready got %0b want 1", bus.ready); else passed++;
  endtask

  task automatic test_store();
    logic [17:0] exp_addr [1:4] = '{18'd2, 18'd2, 18'd3, 18'd3};
    logic        exp_we   [1:4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [15:0] exp_dq   [1:4] = '{16'hBEEF, 16'hBEEF, 16'hDEAD, 16'hDEAD};
    next_cycle();
    bus.wr_en = 1'b1; bus.address = 32'd1028; bus.write_data = 32'hDEADBEEF;
    #1;
    checks++; if (bus.ready !== 1'b0) $display("FAIL st_c0_ready got %0b want 0", bus.ready); else passed++;
    for (int c = 1; c <= 4; c++) begin
      next_cycle();
      bus.wr_en = 1'b0;
      checks++; if (bus.sram_addr !== exp_addr[c]) $display("FAIL st_c%0d_addr got %0d want %0d", c, bus.sram_addr, exp_addr[c]); else passed++;
      checks++; if (bus.sram_we_n !== exp_we[c]) $display("FAIL st_c%0d_we_n got %0b want %0b", c, bus.sram_we_n, exp_we[c]); else passed++;
      checks++; if (bus.sram_dq_out !== exp_dq[c]) $display("FAIL st_c%0d_dq got %h want %h", c, bus.sram_dq_out, exp_dq[c]); else passed++;
      checks++; if ({bus.sram_dq_oe, bus.ready} !== 2'b10) $display("FAIL st_c%0d_oe_ready got %b want 10", c, {bus.sram_dq_oe, bus.ready}); else passed++;
    end
    next_cycle();
    checks++; if (bus.ready !== 1'b1) $display("FAIL st_c5_ready got %0b want 1", bus.ready); else passed++;
    checks++; if ({bus.sram_we_n, bus.sram_dq_oe, bus.sram_dq_out} !== {1'b1, 1'b0, 16'h0}) $display("FAIL st_c5_idle_pins got %b want 1_0_0", {bus.sram_we_n, bus.sram_dq_oe, bus.sram_dq_out}); else passed++;
    next_cycle();
    checks++; if (bus.ready !== 1'b1) $display("FAIL st_c6_ready got %0b want 1", bus.ready); else passed++;
    checks++; if (bus.sram_addr !== 18'd3) $display("FAIL st_c6_addr_hold got %0d want 3", bus.sram_addr); else passed++;
    checks++; if ({mem[3], mem[2]} !== 32'hDEADBEEF) $display("FAIL st_mem got %h want deadbeef", {mem[3], mem[2]}); else passed++;
  endtask

  task automatic test_load_back();
    next_cycle();
    bus.rd_en = 1'b1; bus.address = 32'd1028;
    for (int c = 1; c <= 4; c++) begin
      next_cycle();
      bus.rd_en = 1'b0;
      checks++; if ({bus.sram_dq_oe, bus.sram_we_n, bus.ready} !== 3'b010) $display("FAIL ld_c%0d_oe_we_ready got %b want 010", c, {bus.sram_dq_oe, bus.sram_we_n, bus.ready}); else passed++;
    end
    next_cycle();
    checks++; if (bus.ready !== 1'b1) $display("FAIL ld_c5_ready got %0b want 1", bus.ready); else passed++;
    checks++; if (bus.read_data !== 32'hDEADBEEF) $display("FAIL ld_c5_rdata got %h want deadbeef", bus.read_data); else passed++;
    next_cycle();
    next_cycle();
    checks++; if (bus.read_data !== 32'hDEADBEEF) $display("FAIL ld_hold_rdata got %h want deadbeef", bus.read_data); else passed++;
  endtask

  task automatic test_back_to_back();
    next_cycle();
    bus.rd_en = 1'b1; bus.address = 32'd1028;
    for (int c = 1; c <= 4; c++) next_cycle();
    next_cycle();
    checks++; if (bus.ready !== 1'b1) $display("FAIL b2b_c5_ready got %0b want 1", bus.ready); else passed++;
    checks++; if (bus.read_data !== 32'hDEADBEEF) $display("FAIL b2b_c5_rdata got %h want deadbeef", bus.read_data); else passed++;
    bus.address = 32'd1032;
    next_cycle();
    checks++; if (bus.ready !== 1'b0) $display("FAIL b2b_c6_ready got %0b want 0", bus.ready); else passed++;
    for (int c = 7; c <= 10; c++) begin
      next_cycle();
      bus.rd_en = 1'b0;
      checks++; if (bus.sram_addr !== ((c < 9) ? 18'd4 : 18'd5)) $display("FAIL b2b_c%0d_addr got %0d want %0d", c, bus.sram_addr, (c < 9) ? 4 : 5); else passed++;
    end
    next_cycle();
    checks++; if (bus.ready !== 1'b1) $display("FAIL b2b_c11_ready got %0b want 1", bus.ready); else passed++;
    checks++; if (bus.read_data !== 32'h22221111) $display("FAIL b2b_c11_rdata got %h want 22221111", bus.read_data); else passed++;
  endtask

  task automatic test_reset_mid_write();
    next_cycle();
    bus.wr_en = 1'b1; bus.address = 32'd1028; bus.write_data = 32'h12345678;
    next_cycle();
    bus.wr_en = 1'b0;
    next_cycle();
    next_cycle();
    checks++; if (bus.sram_we_n !== 1'b0) $display("FAIL rmw_c3_we_n got %0b want 0", bus.sram_we_n); else passed++;
    reset = 1'b0;
    #1;
    checks++; if ({bus.sram_we_n, bus.sram_dq_oe} !== 2'b10) $display("FAIL rmw_pins got %b want 10", {bus.sram_we_n, bus.sram_dq_oe}); else passed++;
    checks++; if (bus.read_data !== 32'h0) $display("FAIL rmw_rdata got %h want 0", bus.read_data); else passed++;
    next_cycle();
    reset = 1'b1;
    next_cycle();
    checks++; if ({bus.ready, bus.sram_we_n, bus.sram_dq_oe} !== 3'b110) $display("FAIL rmw_idle got %b want 110", {bus.ready, bus.sram_we_n, bus.sram_dq_oe}); else passed++;
    checks++; if (mem[3] !== 16'hDEAD) $display("FAIL rmw_mem3 got %h want dead", mem[3]); else passed++;
  endtask

  task automatic test_simultaneous();
    next_cycle();
    bus.rd_en = 1'b1; bus.wr_en = 1'b1; bus.address = 32'd1032; bus.write_data = 32'hCAFEF00D;
    next_cycle();
    bus.rd_en = 1'b0; bus.wr_en = 1'b0;
    checks++; if ({bus.sram_dq_oe, bus.sram_we_n} !== 2'b10) $display("FAIL sim_c1_oe_we got %b want 10", {bus.sram_dq_oe, bus.sram_we_n}); else passed++;
    checks++; if (bus.sram_dq_out !== 16'hF00D) $display("FAIL sim_c1_dq got %h want f00d", bus.sram_dq_out); else passed++;
    next_cycle();
    next_cycle();
    checks++; if ({bus.sram_addr, bus.sram_dq_out} !== {18'd5, 16'hCAFE}) $display("FAIL sim_c3_addr_dq got %0d/%h want 5/cafe", bus.sram_addr, bus.sram_dq_out); else passed++;
    next_cycle();
    next_cycle();
    checks++; if (bus.ready !== 1'b1) $display("FAIL sim_c5_ready got %0b want 1", bus.ready); else passed++;
    checks++; if (bus.read_data !== 32'h0) $display("FAIL sim_rdata got %h want 0", bus.read_data); else passed++;
    checks++; if ({mem[5], mem[4]} !== 32'hCAFEF00D) $display("FAIL sim_mem got %h want cafef00d", {mem[5], mem[4]}); else passed++;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    test_reset();
    test_store();
    test_load_back();
    test_back_to_back();
    test_reset_mid_write();
    test_simultaneous();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
